// File: rtl/hazard_stall_controller.sv
// Pipeline hazard stall controller: load-use bubbles, branch flush,
// multi-cycle mul/div wait state and a saturating stall-cycle counter.
module hazard_stall_controller (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        LoadUseHazard,
   input  logic        BranchTaken,
   input  logic        MulDivStart,
   input  logic [3:0]  MulDivCycles,
   output logic        PCWrite,
   output logic        IF_IDWrite,
   output logic        IF_IDFlush,
   output logic        ID_EXBubble,
   output logic        Busy,
   output logic [15:0] StallCount
);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MD_WAIT = 1'b1;

   logic [0:0]  state;
   logic [0:0]  state_nxt;
   logic [3:0]  wait_cnt;
   logic [3:0]  wait_cnt_nxt;
   logic        md_go;
   logic        in_wait;
   logic        sel_rst;
   logic        sel_wait;
   logic        sel_lu;
   logic        sel_br;
   logic        cnt_sat;

   // Only ops of two or more cycles need the pipeline held
   assign md_go   = MulDivStart && (MulDivCycles >= 4'd2);
   assign in_wait = (state == MD_WAIT);
   assign cnt_sat = (StallCount == 16'hFFFF);

   // Mutually exclusive selects, ordered reset > wait > load-use > branch
   assign sel_rst  = !Rst_n;
   assign sel_wait = Rst_n && in_wait;
   assign sel_lu   = Rst_n && !in_wait && LoadUseHazard;
   assign sel_br   = Rst_n && !in_wait && !LoadUseHazard && BranchTaken;

   // Pipeline control outputs (Mealy in RUN, Moore in MD_WAIT)
   always_comb begin
      PCWrite     = 1'b1;
      IF_IDWrite  = 1'b1;
      IF_IDFlush  = 1'b0;
      ID_EXBubble = 1'b0;
      unique case (1'b1)
         sel_rst: begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            IF_IDFlush  = 1'b1;
            ID_EXBubble = 1'b1;
         end
         sel_wait: begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXBubble = 1'b1;
         end
         sel_lu: begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXBubble = 1'b1;
         end
         sel_br: begin
            IF_IDFlush  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Next state and wait counter; start requests ignored while waiting
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      unique case (state)
         RUN: begin
            if (md_go) begin
               state_nxt    = MD_WAIT;
               wait_cnt_nxt = MulDivCycles - 4'd1;
            end
         end
         MD_WAIT: begin
            if (wait_cnt <= 4'd1) begin
               state_nxt    = RUN;
               wait_cnt_nxt = 4'd0;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = 4'd0;
         end
      endcase
   end

   // State and wait counter registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state    <= RUN;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Count cycles where the PC is held, saturating at all-ones
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         StallCount <= 16'd0;
      end else if (!PCWrite && !cnt_sat) begin
         StallCount <= StallCount + 16'd1;
      end
   end

   assign Busy = in_wait;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios
// plus randomized traffic against a cycle-count reference model.
module tb_hazard_stall_controller;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        LoadUseHazard;
   logic        BranchTaken;
   logic        MulDivStart;
   logic [3:0]  MulDivCycles;
   logic        PCWrite;
   logic        IF_IDWrite;
   logic        IF_IDFlush;
   logic        ID_EXBubble;
   logic        Busy;
   logic [15:0] StallCount;

   int          checks = 0;
   int          failures = 0;
   int          m_wait = 0;
   int          m_stalls = 0;
   logic [4:0]  exp_out;

   hazard_stall_controller dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .LoadUseHazard(LoadUseHazard),
      .BranchTaken  (BranchTaken),
      .MulDivStart  (MulDivStart),
      .MulDivCycles (MulDivCycles),
      .PCWrite      (PCWrite),
      .IF_IDWrite   (IF_IDWrite),
      .IF_IDFlush   (IF_IDFlush),
      .ID_EXBubble  (ID_EXBubble),
      .Busy         (Busy),
      .StallCount   (StallCount)
   );

   always #5 Clk = ~Clk;

   // exp_out = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy}
   task automatic drive(input logic rst, input logic lu, input logic br,
                        input logic ms, input logic [3:0] n);
      logic busy;
      Rst_n         = rst;
      LoadUseHazard = lu;
      BranchTaken   = br;
      MulDivStart   = ms;
      MulDivCycles  = n;
      busy = (m_wait > 0);
      if (!rst)          exp_out = {4'b0011, busy};
      else if (busy)     exp_out = 5'b00011;
      else if (lu)       exp_out = 5'b00010;
      else if (br)       exp_out = 5'b11100;
      else               exp_out = 5'b11000;
      #1;
   endtask

   task automatic tick();
      @(posedge Clk);
      if (!Rst_n) begin
         m_wait   = 0;
         m_stalls = 0;
      end else begin
         if (!exp_out[4] && m_stalls < 65535) m_stalls++;
         if (m_wait > 0) m_wait--;
         else if (MulDivStart && MulDivCycles >= 4'd2)
            m_wait = int'(MulDivCycles) - 1;
      end
      @(negedge Clk);
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
      checks++;
      if (obs !== 5'b00110) begin
         failures++;
         $display("FAIL reset_gate got=%b exp=%b", obs, 5'b00110);
      end
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
         obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
         checks++;
         if (obs !== 5'b11000 || StallCount !== 16'd0) begin
            failures++;
            $display("FAIL idle_%0d got=%b/%0d exp=11000/0",
                     i, obs, StallCount);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      logic [4:0] obs;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
      checks++;
      if (obs !== 5'b00010) begin
         failures++;
         $display("FAIL load_use got=%b exp=00010", obs);
      end
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
      checks++;
      if (obs !== 5'b11000 || StallCount !== 16'd1) begin
         failures++;
         $display("FAIL load_use_after got=%b/%0d exp=11000/1",
                  obs, StallCount);
      end
      tick();
   endtask

   task automatic test_lu_branch();
      logic [4:0] obs;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
      checks++;
      if (obs !== 5'b00010) begin
         failures++;
         $display("FAIL lu_wins got=%b exp=00010", obs);
      end
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
      checks++;
      if (obs !== 5'b11100 || StallCount !== 16'd2) begin
         failures++;
         $display("FAIL branch_flush got=%b/%0d exp=11100/2",
                  obs, StallCount);
      end
      tick();
   endtask

   task automatic test_muldiv();
      logic [4:0] obs;
      int busy_cycles;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
      obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
      checks++;
      if (obs !== 5'b11000) begin
         failures++;
         $display("FAIL md_issue got=%b exp=11000", obs);
      end
      tick();
      busy_cycles = 0;
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 1'($urandom), 1'b1, 1'b1, 4'd9);
         if (!Busy) break;
         busy_cycles++;
         obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
         checks++;
         if (obs !== 5'b00011) begin
            failures++;
            $display("FAIL md_wait_%0d got=%b exp=00011", k, obs);
         end
         tick();
      end
      checks++;
      if (busy_cycles != 4 || StallCount !== 16'd4) begin
         failures++;
         $display("FAIL md_len got=%0d/%0d exp=4/4",
                  busy_cycles, StallCount);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
   endtask

   task automatic test_short_muldiv();
      logic [4:0] obs;
      do_reset();
      for (int n = 0; n < 2; n++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, 4'(n));
         tick();
         drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
         obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
         checks++;
         if (obs !== 5'b11000 || StallCount !== 16'd0) begin
            failures++;
            $display("FAIL md_short_n%0d got=%b/%0d exp=11000/0",
                     n, obs, StallCount);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [4:0] obs;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
      checks++;
      if (obs !== 5'b00111 || StallCount !== 16'd1) begin
         failures++;
         $display("FAIL rst_mid_gate got=%b/%0d exp=00111/1",
                  obs, StallCount);
      end
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
      checks++;
      if (obs !== 5'b11000 || StallCount !== 16'd0) begin
         failures++;
         $display("FAIL rst_mid_after got=%b/%0d exp=11000/0",
                  obs, StallCount);
      end
      tick();
   endtask

   task automatic test_random();
      logic [4:0] obs;
      int bad = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 39) != 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 4) == 0),
               4'($urandom));
         obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, Busy};
         checks++;
         if (obs !== exp_out || StallCount !== 16'(m_stalls)) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL rand_%0d got=%b/%0d exp=%b/%0d",
                        i, obs, StallCount, exp_out, m_stalls);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 65534; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
         tick();
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checks++;
      if (StallCount !== 16'hFFFE) begin
         failures++;
         $display("FAIL sat_pre got=%h exp=fffe", StallCount);
      end
      for (int i = 0; i < 70000 - 65534; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
         tick();
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++;
      if (StallCount !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_hold got=%h exp=ffff", StallCount);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_lu_branch();
      test_muldiv();
      test_short_muldiv();
      test_reset_mid_wait();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have port Clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port Rst_n, input, 1, reset: one clock; reset is synchronous and active-low.
REQ-003 SHALL have port LoadUseHazard, input, 1, load-use stall request from HazardDetectionUnit (ID stage, combinational).
REQ-004 SHALL have port BranchTaken, input, 1, branch resolved taken in ID this cycle.
REQ-005 SHALL have port MulDivStart, input, 1, multi-cycle mul/div op entering EX this cycle.
REQ-006 SHALL have port MulDivCycles, input, 4, total EX latency N of the issuing mul/div op, sampled with MulDivStart.
REQ-007 SHALL have port PCWrite, output, 1, PC update enable.
REQ-008 SHALL have port IF_IDWrite, output, 1, IF/ID register write enable.
REQ-009 SHALL have port IF_IDFlush, output, 1, zero IF/ID instruction (squash fetched instruction).
REQ-010 SHALL have port ID_EXBubble, output, 1, select zero controls into ID/EX (bubble insert).
REQ-011 SHALL have port Busy, output, 1, high while in MD_WAIT.
REQ-012 SHALL have port StallCount, output, 16, count of cycles with PCWrite=0.

Function
REQ-013 SHALL implement two states: RUN, MD_WAIT; plus 4-bit down-counter WaitCnt.
REQ-014 RUN, no requests: PCWrite=1, IF_IDWrite=1, IF_IDFlush=0, ID_EXBubble=0.
REQ-015 RUN, LoadUseHazard=1: same cycle (Mealy) PCWrite=0, IF_IDWrite=0, ID_EXBubble=1, IF_IDFlush=0; state stays RUN.
REQ-016 RUN, BranchTaken=1 and LoadUseHazard=0: same cycle IF_IDFlush=1, PCWrite=1, IF_IDWrite=1, ID_EXBubble=0.
REQ-017 BranchTaken SHALL be ignored when LoadUseHazard=1 in same cycle (load-use wins, no flush).
REQ-018 RUN, MulDivStart=1 with MulDivCycles N>=2: next state MD_WAIT, WaitCnt<=N-1; current-cycle outputs per REQ-014..017.
REQ-019 MulDivStart with N=0 or N=1 SHALL cause no stall and no state change.
REQ-020 MD_WAIT (Moore): PCWrite=0, IF_IDWrite=0, ID_EXBubble=1, IF_IDFlush=0, regardless of LoadUseHazard/BranchTaken.
REQ-021 MD_WAIT: WaitCnt decrements each cycle; when WaitCnt=1 at a clock edge, next state RUN, WaitCnt<=0; MD_WAIT lasts exactly N-1 cycles.
REQ-022 MulDivStart SHALL be ignored in MD_WAIT (no counter reload).
REQ-023 StallCount SHALL increment by 1 on each edge where PCWrite=0 and Rst_n=1, saturating at 16'hFFFF.
REQ-024 Busy SHALL equal (state==MD_WAIT), registered.

Reset
REQ-025 Rst_n=0 at a rising edge SHALL set state=RUN, WaitCnt=0, StallCount=0, including mid-MD_WAIT.
REQ-026 While Rst_n=0, outputs SHALL be PCWrite=0, IF_IDWrite=0, IF_IDFlush=1, ID_EXBubble=1 (combinational gate); StallCount not incremented.
REQ-027 First cycle after reset release SHALL be RUN with Busy=0, StallCount=0.

Verification
REQ-028 Reset then idle 5 cycles -> PCWrite=1, IF_IDWrite=1, IF_IDFlush=0, ID_EXBubble=0, Busy=0, StallCount=0.
REQ-029 LoadUseHazard=1 for 1 cycle -> that cycle PCWrite=0, IF_IDWrite=0, ID_EXBubble=1; next cycle all RUN defaults; StallCount=1.
REQ-030 LoadUseHazard=1 and BranchTaken=1 same cycle -> IF_IDFlush=0, stall outputs as REQ-015; BranchTaken alone next cycle -> IF_IDFlush=1, PCWrite=1.
REQ-031 MulDivStart=1, MulDivCycles=5 -> Busy=1 for exactly 4 cycles with PCWrite=0, ID_EXBubble=1; BranchTaken/MulDivStart pulsed during wait ignored; StallCount=4 after.
REQ-032 MulDivCycles=1 and 0 with MulDivStart=1 -> Busy stays 0, no stall cycles.
REQ-033 Rst_n=0 on 2nd cycle of MD_WAIT (N=8) -> next edge state RUN, Busy=0, StallCount=0; StallCount saturation checked by forcing 70000 stall cycles -> holds 16'hFFFF.
